divider_8bits: RTL
==================

# divider_8bits

Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake. Each trial subtraction is performed as an add of the inverted divisor with carry-in 1, built from the team's 4-bit carry-lookahead adder slices. A carry-out of 1 means no borrow. This gives the arithmetic datapath a divide unit alongside the existing combinational add path.

## Interface
- `W`, default 8: operand width in bits; must be a multiple of 4 and at least 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request to begin a division; sampled on the rising edge.
- `dividend`  in  W  unsigned dividend; sampled only on the accepting edge.
- `divisor`  in  W  unsigned divisor; sampled only on the accepting edge.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse; `q`, `r` and `dz` are valid in this cycle.
- `q`  out  W  quotient.
- `r`  out  W  remainder; present only with `DIVIDER_8BITS_REM_EN`.
- `dz`  out  1  divide-by-zero flag for the last completed operation.

## Operation
- **States:** IDLE, RUN, DONE.
- **Acceptance:**
  - A start is accepted on a rising edge where `start`=1 and `busy`=0, i.e. in IDLE or DONE.
  - The accepting edge latches `dividend` and `divisor`, clears the partial remainder R (W+1 bits) and loads the quotient shift register with the dividend.
  - If `start`=1 while `busy`=1, it is ignored and the operands are not resampled.
- **RUN iteration (W edges, bit i from W-1 down to 0):**
  - Shift: R' = {R[W-1:0], msb of quotient register}.
  - Trial: T = R' + ~{0,divisor} + 1.
  - If T has no borrow (carry-out of the W+1-bit add = 1): R = T and shift 1 into the quotient LSB.
  - Otherwise: R = R' and shift 0 into the quotient LSB.
  - A counter runs W-1 down to 0. RUN → DONE on the edge that processes bit 0.
- **Divide by zero:**
  - If `divisor`=0 at the accepting edge, the block goes IDLE → DONE directly and skips RUN.
  - Results: `q` = all ones, `r` = `dividend`, `dz` = 1.
- **Leaving DONE:**
  - DONE → IDLE next edge if no start.
  - DONE → RUN (or DONE, for a zero divisor) if a start is accepted, giving back-to-back operations.
- **Output hold:**
  - `q`, `r` and `dz` hold their values from DONE until the next accepted start.
  - They are undefined-but-stable while RUN is in progress; they change only as the internal registers iterate. The verifier must not check them outside `done`.
- **Arithmetic:** all operands unsigned. Guarantee: `q`*`divisor` + `r` = `dividend` with `r` < `divisor` (divisor ≠ 0).

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `q`=0, `r`=0, `dz`=0, counter=0.
- **Normal latency:**
  - Accept at edge 0.
  - `busy`=1 from after edge 0 through the cycle before edge W.
  - `done`=1 for exactly the one cycle after edge W, when `busy`=0.
  - Total: W cycles from accept to done.
- **Divide-by-zero latency:** `done`=1 in the cycle after edge 0; `busy` never asserts.
- `busy` and `done` are never high together.
- **Reset mid-operation:** asserting `rst_n`=0 during RUN immediately returns all state and outputs to reset values. No `done` is produced for the aborted operation.
- **Start in a `done` cycle:** accepted. `done` drops and `busy` rises after that edge.

## Configuration
- `DIVIDER_8BITS_REM_EN` defined:
  - Port `r` exists and is driven from R[W-1:0] at completion.
  - On divide by zero, `r` is driven with `dividend`.
- `DIVIDER_8BITS_REM_EN` undefined:
  - Port `r` is absent.
  - The final remainder is not stored as an output register; the internal R is kept only for iteration.
  - Quotient, `dz` and timing are unchanged.

## Test plan
- 200 ÷ 7 (W=8): start at edge 0 → `done` after edge 8, `q`=28, `r`=4, `dz`=0; `busy` high for 8 cycles.
- 255 ÷ 1 → `q`=255, `r`=0. 5 ÷ 9 → `q`=0, `r`=5. 0 ÷ 3 → `q`=0, `r`=0.
- 77 ÷ 0 → `done` in the cycle after the accepting edge, `q`=255, `r`=77, `dz`=1, `busy` never 1.
- 100 ÷ 10 running; raise `start` with 9 ÷ 3 at edge 4 → ignored; result `q`=10, `r`=0. Then start 9 ÷ 3 in the `done` cycle → `q`=3, `r`=0, W cycles later.
- Drop `rst_n` at edge 5 of 250 ÷ 6 → all outputs 0 immediately, no `done`. A subsequent 250 ÷ 6 gives `q`=41, `r`=4.
- Random sweep of 10 000 operand pairs, with and without `DIVIDER_8BITS_REM_EN` → `q`*`divisor` + `r` = `dividend`, `r` < `divisor`, and latency always W.

Source files
------------

// File: rtl/divider_8bits_if.sv
// Start/done handshake and operand/result bundle for divider_8bits.
// The remainder signal r exists only when DIVIDER_8BITS_REM_EN is defined.
interface divider_8bits_if #(
    parameter int W = 8
);
    // Handshake: a request is taken on a rising edge with start=1 and busy=0;
    // start while busy=1 is ignored; done pulses one cycle with results valid.
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
`ifdef DIVIDER_8BITS_REM_EN
    logic [W-1:0] r;
`endif
    logic         dz;

`ifdef DIVIDER_8BITS_REM_EN
    modport master (output start, dividend, divisor, input busy, done, q, r, dz);
    modport slave  (input start, dividend, divisor, output busy, done, q, r, dz);
`else
    modport master (output start, dividend, divisor, input busy, done, q, dz);
    modport slave  (input start, dividend, divisor, output busy, done, q, dz);
`endif
endinterface

// File: rtl/divider_8bits.sv
// Iterative unsigned restoring divider, one quotient bit per clock, built on 4-bit CLA slices.
// Optional remainder output enabled by defining DIVIDER_8BITS_REM_EN.
module divider_8bits_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
    end
endmodule

module divider_8bits #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    divider_8bits_if.slave      bus,
    output logic [1:0]          state_dbg
);
    localparam int NS = W / 4;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dvs;
    logic [W-1:0]  quo;
    // The partial remainder is always below the divisor between steps, so W bits
    // hold it; the W+1-bit quantity only exists as the shifted trial operand.
    logic [W-1:0]  rem;
    logic          dz_q;
`ifdef DIVIDER_8BITS_REM_EN
    logic [W-1:0]  rem_out;
`endif

    logic [W:0]    r_shift;
    logic [W:0]    sub_b;
    logic [W-1:0]  trial;
    logic [NS:0]   carry;
    logic          no_borrow;
    logic [W-1:0]  rem_next;

    assign r_shift  = {rem, quo[W-1]};
    assign sub_b    = ~{1'b0, dvs};
    assign carry[0] = 1'b1;

    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
        divider_8bits_cla4 u_cla (
            .a    (r_shift[4*gi +: 4]),
            .b    (sub_b[4*gi +: 4]),
            .cin  (carry[gi]),
            .s    (trial[4*gi +: 4]),
            .cout (carry[gi+1])
        );
    end

    // Top bit of the W+1-bit add: only its carry-out matters (1 means no borrow).
    assign no_borrow = (r_shift[W] & sub_b[W]) | ((r_shift[W] ^ sub_b[W]) & carry[NS]);
    assign rem_next  = no_borrow ? trial : r_shift[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dvs     <= '0;
            quo     <= '0;
            rem     <= '0;
            dz_q    <= 1'b0;
`ifdef DIVIDER_8BITS_REM_EN
            rem_out <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dvs <= bus.divisor;
                        rem <= '0;
                        if (bus.divisor == '0) begin
                            quo     <= '1;
                            dz_q    <= 1'b1;
                            cnt     <= '0;
                            state   <= DONE;
`ifdef DIVIDER_8BITS_REM_EN
                            rem_out <= bus.dividend;
`endif
                        end else begin
                            quo   <= bus.dividend;
                            dz_q  <= 1'b0;
                            cnt   <= CW'(W - 1);
                            state <= RUN;
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= {quo[W-2:0], no_borrow};
                    if (cnt == '0) begin
                        state   <= DONE;
`ifdef DIVIDER_8BITS_REM_EN
                        rem_out <= rem_next;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.q     = quo;
    assign bus.dz    = dz_q;
`ifdef DIVIDER_8BITS_REM_EN
    assign bus.r     = rem_out;
`endif
    assign state_dbg = state;
endmodule
